// File: rtl/cv32e41p_rf_writeback_pkg.sv
// Shared sizing for the register-file writeback block (outstanding-load queue geometry).
package cv32e41p_rf_writeback_pkg;

  localparam int unsigned LQ_DEPTH_DEFAULT = 2;
  localparam int unsigned LQ_PTR_W = $clog2(LQ_DEPTH_DEFAULT);
  localparam int unsigned LQ_CNT_W = $clog2(LQ_DEPTH_DEFAULT + 1);

  function automatic int unsigned lq_ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned lq_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cv32e41p_wb_addr_fifo.sv
// In-order queue of load destination addresses; head is valid whenever o_empty is low.
module cv32e41p_wb_addr_fifo
  import cv32e41p_rf_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = LQ_DEPTH_DEFAULT,
  parameter int unsigned AW    = 5,
  parameter int unsigned PTR_W = LQ_PTR_W,
  parameter int unsigned CNT_W = LQ_CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [AW-1:0] i_push_dat,
  output logic [AW-1:0] o_head,
  output logic          o_full,
  output logic          o_empty
);

  logic [AW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rptr];

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_dat;
  end

endmodule

// File: rtl/cv32e41p_rf_writeback.sv
// Register-file writeback: registered ALU port A, load port B fed by an in-order address queue, pending-load hazards.
// Define CV32E41P_WB_BYPASS_EN to drive port B combinationally from the load response.
module cv32e41p_rf_writeback
  import cv32e41p_rf_writeback_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LQ_DEPTH   = LQ_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_we_i,
  input  logic [ADDR_WIDTH-1:0] ex_waddr_i,
  input  logic [DATA_WIDTH-1:0] ex_wdata_i,
  input  logic                  lsu_issue_i,
  input  logic [ADDR_WIDTH-1:0] lsu_issue_waddr_i,
  output logic                  lsu_issue_ready_o,
  input  logic                  lsu_rvalid_i,
  input  logic [DATA_WIDTH-1:0] lsu_rdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  input  logic [ADDR_WIDTH-1:0] raddr_c_i,
  output logic                  raw_hazard_o,
  output logic                  waw_hazard_o,
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o,
  output logic                  we_b_o,
  output logic                  rsp_error_o
);

  localparam int unsigned NREG = 2 ** ADDR_WIDTH;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_head;
  logic                  w_clr_vld;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic [NREG-1:0]       w_pending_nxt;
  logic [NREG-1:0]       r_pending;
  logic                  r_we_a;
  logic [ADDR_WIDTH-1:0] r_waddr_a;
  logic [DATA_WIDTH-1:0] r_wdata_a;
  logic                  r_rsp_error;

  assign w_push            = lsu_issue_i & ~w_full;
  assign w_pop             = lsu_rvalid_i & ~w_empty;
  assign lsu_issue_ready_o = ~w_full;

  cv32e41p_wb_addr_fifo #(
    .DEPTH (LQ_DEPTH),
    .AW    (ADDR_WIDTH),
    .PTR_W (lq_ptr_w(LQ_DEPTH)),
    .CNT_W (lq_cnt_w(LQ_DEPTH))
  ) u_addr_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_push_dat (lsu_issue_waddr_i),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we_a      <= 1'b0;
      r_waddr_a   <= '0;
      r_wdata_a   <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      r_we_a      <= ex_we_i & (ex_waddr_i != '0);
      r_rsp_error <= r_rsp_error | (lsu_rvalid_i & w_empty);
      if (ex_we_i && (ex_waddr_i != '0)) begin
        r_waddr_a <= ex_waddr_i;
        r_wdata_a <= ex_wdata_i;
      end
    end
  end

  assign we_a_o      = r_we_a;
  assign waddr_a_o   = r_waddr_a;
  assign wdata_a_o   = r_wdata_a;
  assign rsp_error_o = r_rsp_error;

`ifdef CV32E41P_WB_BYPASS_EN
  assign we_b_o     = w_pop;
  assign waddr_b_o  = w_pop ? w_head : '0;
  assign wdata_b_o  = w_pop ? lsu_rdata_i : '0;
  assign w_clr_vld  = w_pop;
  assign w_clr_addr = w_head;
`else
  logic                  r_we_b;
  logic [ADDR_WIDTH-1:0] r_waddr_b;
  logic [DATA_WIDTH-1:0] r_wdata_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we_b    <= 1'b0;
      r_waddr_b <= '0;
      r_wdata_b <= '0;
    end else begin
      r_we_b <= w_pop;
      if (w_pop) begin
        r_waddr_b <= w_head;
        r_wdata_b <= lsu_rdata_i;
      end
    end
  end

  assign we_b_o     = r_we_b;
  assign waddr_b_o  = r_waddr_b;
  assign wdata_b_o  = r_wdata_b;
  // Pending stays set through the registered write cycle and drops as the RF captures it.
  assign w_clr_vld  = r_we_b;
  assign w_clr_addr = r_waddr_b;
`endif

  // A new load to a register overrides a completing one in the same cycle.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_clr_vld) w_pending_nxt[w_clr_addr] = 1'b0;
    if (w_push && (lsu_issue_waddr_i != '0)) w_pending_nxt[lsu_issue_waddr_i] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pending <= '0;
    else     r_pending <= w_pending_nxt;
  end

  assign raw_hazard_o = r_pending[raddr_a_i] | r_pending[raddr_b_i] | r_pending[raddr_c_i];
  assign waw_hazard_o = ex_we_i & r_pending[ex_waddr_i];

endmodule
